// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial y = a - b, LSB first, one borrow flop.
// Optional signed-overflow output enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] y,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              bw_q, bw_d;
  logic              bo_q, bo_d;
  logic              dbit;
  logic              bw_nxt;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic              am_q, am_d;
  logic              bm_q, bm_d;
  logic              ov_q, ov_d;
`endif

  assign dbit   = sa_q[0] ^ sb_q[0] ^ bw_q;
  assign bw_nxt = (~sa_q[0] & sb_q[0])
                | (~(sa_q[0] ^ sb_q[0]) & bw_q);

  // Next-state and datapath updates; start is honoured in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    bw_d    = bw_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ov_d    = ov_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          sa_d    = a;
          sb_d    = b;
          bw_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          am_d    = a[WIDTH-1];
          bm_d    = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {dbit, res_q[WIDTH-1:1]};
        bw_d  = bw_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          y_d     = {dbit, res_q[WIDTH-1:1]};
          bo_d    = bw_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ov_d    = (am_q != bm_q) && (dbit != am_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      bw_q    <= 1'b0;
      bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ov_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      bw_q    <= bw_d;
      bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      ov_q    <= ov_d;
`endif
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign y          = y_q;
  assign borrow_out = bo_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow   = ov_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing y = a - b, LSB first, one bit per clock through a single borrow flip-flop. It is the sequential, subtracting counterpart of the team's parallel add-with-carry ripple adder. The block trades latency for area in datapaths that already have a free clock. It uses a start/busy/done handshake so a controller can issue back-to-back operations.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
a  input  WIDTH  minuend; captured on an accepted start
b  input  WIDTH  subtrahend; captured on an accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; y and borrow_out are valid
y  output  WIDTH  difference a - b mod 2^WIDTH; held until the next accepted start
borrow_out  output  1  high when a < b (unsigned); held with y

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, y=0, borrow_out=0.
  - Internal shift registers, borrow flop and bit counter all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - If start=1 at a rising edge: latch a→sa, b→sb, borrow←0, cnt←0; go to SHIFT.
- SHIFT:
  - busy=1. Each edge processes bit sa[0], sb[0] with borrow bw:
    - d = sa[0]^sb[0]^bw
    - bw_next = (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & bw)
  - sa, sb shift right by one. d enters the MSB of the result register, which shifts right. cnt increments.
  - When cnt reaches WIDTH-1 at that edge, go to DONE. On the same edge, load y←completed result and borrow_out←bw_next.
- DONE:
  - busy=0, done=1 for exactly one cycle; next edge goes to IDLE.
  - A start sampled high in DONE is accepted exactly as in IDLE. This gives back-to-back issue with no idle bubble.
- Latency: start accepted at edge k → y/borrow_out update and done rises at edge k+WIDTH; done falls at edge k+WIDTH+1.
- start while busy=1 is ignored; a and b may change freely while busy.
- y and borrow_out keep their last values in IDLE and SHIFT, and change only on the completing SHIFT edge.
- Reset asserted mid-operation aborts immediately. No done pulse is produced, and y/borrow_out return to 0.
- Counter width is $clog2(WIDTH). Counter wrap is never reached, because the FSM exits SHIFT first.

Optional Feature:
SERIAL_SUB_OVERFLOW_EN:
- Defined:
  - Adds output port overflow (1 bit): signed two's-complement overflow of a - b.
  - overflow = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]), computed from the latched operands.
  - Registered alongside y; reset value 0; held with y.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, reset then start with a=9, b=3 → done at edge k+4; y=6, borrow_out=0, busy high for 4 cycles.
- a=3, b=9 → y=4'hA, borrow_out=1.
- a=0, b=1 → y=4'hF, borrow_out=1; then a=0, b=0 → y=0, borrow_out=0.
- start held high continuously with a=5, b=2 → done every 5 cycles; y=3 each time; no start lost or duplicated.
- Change a/b and pulse start at edge k+2 during busy → ignored; result reflects the originally latched operands.
- rst_n low at edge k+2 of a 9-3 operation → y=0, busy=0, no done. With SERIAL_SUB_OVERFLOW_EN: a=7, b=8 → y=4'hF, borrow_out=1, overflow=1; a=5, b=2 → overflow=0.
